keyboard_matrix_map: RTL and testbench

KEYBOARD_MATRIX_MAP -- requirements
Module: keyboard_matrix_map

---
 rtl/keyboard_matrix_map_if.sv | 26 ++
 rtl/keyboard_matrix_map.sv | 163 ++++++++++++++++
 tb/tb_keyboard_matrix_map.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/keyboard_matrix_map_if.sv
// Scan-code input and map-table programming port of keyboard_matrix_map.
// A byte transfers on a rising edge where code_valid and code_ready are both high;
// code must stay stable while code_valid waits for code_ready. map_we is a bare strobe.
interface keyboard_matrix_map_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    localparam int EW = $clog2(ROWS) + $clog2(COLS) + 2;

    logic [7:0]    code;
    logic          code_valid;
    logic          code_ready;
    logic          map_we;
    logic [8:0]    map_addr;
    logic [EW-1:0] map_wdata;

    modport master (
        output code, code_valid, map_we, map_addr, map_wdata,
        input  code_ready
    );

    modport slave (
        input  code, code_valid, map_we, map_addr, map_wdata,
        output code_ready
    );
endinterface

// File: rtl/keyboard_matrix_map.sv
// Decodes PS/2 make/break byte sequences through a programmable 512-entry table
// into an emulated active-low key matrix sensed by a row-scanning host.
module keyboard_matrix_map #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    keyboard_matrix_map_if.slave             bus,
    input  logic [ROWS-1:0]                  scan_in,
    output logic [COLS-1:0]                  scan_out,
    output logic                             restore,
    output logic [$clog2(ROWS*COLS+1)-1:0]   keys_down,
    output logic                             flush,
    output logic [2:0]                       dbg_state
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int EW = RW + CW + 2;
    localparam int KW = $clog2(ROWS*COLS+1);

    localparam logic [RW:0] ROWS_L = (RW+1)'(ROWS);
    localparam logic [CW:0] COLS_L = (CW+1)'(COLS);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] BRK     = 3'd1;
    localparam logic [2:0] EXT     = 3'd2;
    localparam logic [2:0] EXT_BRK = 3'd3;
    localparam logic [2:0] LOOKUP  = 3'd4;
    localparam logic [2:0] APPLY   = 3'd5;

    logic [2:0]                  state_q, state_d;
    logic                        ext_q, ext_d;
    logic                        brk_q, brk_d;
    logic [7:0]                  byte_q, byte_d;
    logic [ROWS-1:0][COLS-1:0]   matrix_q, matrix_d;
    logic                        restore_q, restore_d;
    logic [KW-1:0]               keys_q, keys_d;
    logic                        flush_q, flush_d;

    logic [EW-1:0]               map_mem [512];
    logic [EW-1:0]               entry_q;

    logic                        accept;
    logic                        is_err;
    logic                        ent_valid;
    logic                        ent_restore;
    logic [RW-1:0]               ent_row;
    logic [CW-1:0]               ent_col;
    logic                        pos_ok;

    assign bus.code_ready = (state_q == IDLE) || (state_q == BRK) ||
                            (state_q == EXT)  || (state_q == EXT_BRK);
    assign accept = bus.code_valid && bus.code_ready;
    assign is_err = (bus.code == 8'h00) || (bus.code == 8'hFF);

    assign ent_valid   = entry_q[EW-1];
    assign ent_restore = entry_q[EW-2];
    assign ent_row     = entry_q[CW +: RW];
    assign ent_col     = entry_q[0 +: CW];
    // Non-power-of-two matrices leave encodable positions with no physical key.
    assign pos_ok      = ({1'b0, ent_row} < ROWS_L) && ({1'b0, ent_col} < COLS_L);

    always_comb begin
        state_d   = state_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        byte_d    = byte_q;
        matrix_d  = matrix_q;
        restore_d = restore_q;
        keys_d    = keys_q;
        flush_d   = 1'b0;
        case (state_q)
            IDLE, BRK, EXT, EXT_BRK: begin
                if (accept) begin
                    if (is_err) begin
                        state_d   = IDLE;
                        matrix_d  = '1;
                        restore_d = 1'b0;
                        keys_d    = '0;
                        flush_d   = 1'b1;
                    end else if (bus.code == 8'hE0) begin
                        state_d = ((state_q == IDLE) || (state_q == EXT)) ? EXT : EXT_BRK;
                    end else if ((bus.code == 8'hF0) && (state_q == IDLE)) begin
                        state_d = BRK;
                    end else if ((bus.code == 8'hF0) && (state_q == EXT)) begin
                        state_d = EXT_BRK;
                    end else begin
                        state_d = LOOKUP;
                        byte_d  = bus.code;
                        ext_d   = (state_q == EXT) || (state_q == EXT_BRK);
                        brk_d   = (state_q == BRK) || (state_q == EXT_BRK);
                    end
                end
            end
            LOOKUP: state_d = APPLY;
            APPLY: begin
                state_d = IDLE;
                if (ent_valid) begin
                    if (ent_restore) begin
                        restore_d = !brk_q;
                    end else if (pos_ok) begin
                        // Only real transitions move the count, so typematic repeats are absorbed.
                        if (!brk_q && matrix_q[ent_row][ent_col]) begin
                            matrix_d[ent_row][ent_col] = 1'b0;
                            keys_d = keys_q + KW'(1);
                        end else if (brk_q && !matrix_q[ent_row][ent_col]) begin
                            matrix_d[ent_row][ent_col] = 1'b1;
                            keys_d = keys_q - KW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            byte_q    <= 8'h00;
            matrix_q  <= '1;
            restore_q <= 1'b0;
            keys_q    <= '0;
            flush_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            byte_q    <= byte_d;
            matrix_q  <= matrix_d;
            restore_q <= restore_d;
            keys_q    <= keys_d;
            flush_q   <= flush_d;
        end
    end

    // Table survives reset; a read racing a write to the same index sees the old entry.
    always_ff @(posedge clk) begin
        if (bus.map_we) begin
            map_mem[bus.map_addr] <= bus.map_wdata;
        end
        if (state_q == LOOKUP) begin
            entry_q <= map_mem[{ext_q, byte_q}];
        end
    end

    always_comb begin
        scan_out = '1;
        for (int r = 0; r < ROWS; r++) begin
            if (!scan_in[r]) begin
                scan_out = scan_out & matrix_q[r];
            end
        end
    end

    assign restore   = restore_q;
    assign keys_down = keys_q;
    assign flush     = flush_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_keyboard_matrix_map.sv
// Directed scan-code sequences for keyboard_matrix_map with a queue-based response checker.
module tb_keyboard_matrix_map;
  localparam int KW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    scan_in;
  logic [7:0]    scan_out;
  logic          restore;
  logic [KW-1:0] keys_down;
  logic          flush;
  logic [2:0]    dbg_state;

  keyboard_matrix_map_if #(.ROWS(8), .COLS(8)) bus();

  keyboard_matrix_map #(.ROWS(8), .COLS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .scan_in   (scan_in),
    .scan_out  (scan_out),
    .restore   (restore),
    .keys_down (keys_down),
    .flush     (flush),
    .dbg_state (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: {is_flush, scan_out[7:0], keys_down[6:0], restore}
  logic [16:0] exp_q[$];
  int          exp_cyc_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // kind: 0 = no response, 1 = applied lookup, 2 = flush
  task automatic send(input logic [7:0] b, input int kind, input logic [7:0] s,
                      input logic [KW-1:0] k, input logic r);
    int budget;
    @(negedge clk);
    bus.code = b;
    bus.code_valid = 1'b1;
    budget = 0;
    while (!bus.code_ready && budget < 8) begin
      @(negedge clk);
      budget++;
    end
    chk("ready_before_send", bus.code_ready, 1'b1);
    if (kind != 0) begin
      exp_q.push_back({(kind == 2), s, k, r});
      exp_cyc_q.push_back((kind == 2) ? cyc + 1 : cyc + 3);
    end
    @(posedge clk);
    @(negedge clk);
    bus.code_valid = 1'b0;
    budget = 0;
    while (!bus.code_ready && budget < 8) begin
      @(negedge clk);
      budget++;
    end
    chk("ready_after_send", bus.code_ready, 1'b1);
    @(negedge clk);
  endtask

  task automatic pfx(input logic [7:0] b);
    send(b, 0, 8'h00, '0, 1'b0);
  endtask

  task automatic write_map(input logic [8:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.map_we = 1'b1;
    bus.map_addr = a;
    bus.map_wdata = d;
    @(negedge clk);
    bus.map_we = 1'b0;
  endtask

  // monitor: a response is either ready returning after a lookup, or a flush pulse
  logic        prev_ready = 1'b1;
  logic [16:0] mon_item;
  int          mon_cyc;
  always @(negedge clk) begin
    if (!reset) begin
      prev_ready <= 1'b1;
    end else begin
      if ((!prev_ready && bus.code_ready) || flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_response: flush=%0b scan_out=%0h keys_down=%0d (t=%0t)",
                   flush, scan_out, keys_down, $time);
        end else begin
          mon_item = exp_q.pop_front();
          mon_cyc  = exp_cyc_q.pop_front();
          chk("resp_cycle", cyc, mon_cyc);
          chk("resp_flush", flush, mon_item[16]);
          chk("resp_scan_out", scan_out, mon_item[15:8]);
          chk("resp_keys_down", keys_down, mon_item[7:1]);
          chk("resp_restore", restore, mon_item[0]);
        end
      end
      prev_ready <= bus.code_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    bus.code = 8'h00;
    bus.code_valid = 1'b0;
    bus.map_we = 1'b0;
    bus.map_addr = 9'h000;
    bus.map_wdata = 8'h00;
    scan_in = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_code_ready", bus.code_ready, 1'b1);
    chk("rst_scan_out", scan_out, 8'hFF);
    chk("rst_keys_down", keys_down, 0);
    chk("rst_restore", restore, 1'b0);
    chk("rst_flush", flush, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // entries: {valid, restore, row[2:0], col[2:0]}
    write_map({1'b0, 8'h1C}, 8'h8A);  // row1 col2
    write_map({1'b1, 8'h6C}, 8'hB3);  // row6 col3
    write_map({1'b0, 8'h6C}, 8'h00);  // unmapped
    write_map({1'b0, 8'h09}, 8'hC0);  // restore key
    write_map({1'b0, 8'h1B}, 8'h8D);  // row1 col5

    // make, typematic repeats, break
    scan_in = 8'hFD;
    send(8'h1C, 1, 8'hFB, 7'd1, 1'b0);
    send(8'h1C, 1, 8'hFB, 7'd1, 1'b0);
    send(8'h1C, 1, 8'hFB, 7'd1, 1'b0);
    scan_in = 8'hFF;
    #1 chk("no_row_driven", scan_out, 8'hFF);
    scan_in = 8'hFD;
    pfx(8'hF0);
    send(8'h1C, 1, 8'hFF, 7'd0, 1'b0);

    // extended key only reachable through E0
    scan_in = 8'hBF;
    send(8'h6C, 1, 8'hFF, 7'd0, 1'b0);
    pfx(8'hE0);
    send(8'h6C, 1, 8'hF7, 7'd1, 1'b0);
    pfx(8'hE0);
    pfx(8'hF0);
    send(8'h6C, 1, 8'hFF, 7'd0, 1'b0);

    // restore key leaves matrix and count alone
    scan_in = 8'hFD;
    send(8'h1C, 1, 8'hFB, 7'd1, 1'b0);
    send(8'h09, 1, 8'hFB, 7'd1, 1'b1);
    pfx(8'hF0);
    send(8'h09, 1, 8'hFB, 7'd1, 1'b0);

    // three keys held plus restore, then error byte flush
    pfx(8'hE0);
    send(8'h6C, 1, 8'hFB, 7'd2, 1'b0);
    send(8'h1B, 1, 8'hDB, 7'd3, 1'b0);
    send(8'h09, 1, 8'hDB, 7'd3, 1'b1);
    scan_in = 8'h00;
    #1 chk("all_rows_scan_out", scan_out, 8'hD3);
    send(8'hFF, 2, 8'hFF, 7'd0, 1'b0);
    chk("flush_one_cycle", flush, 1'b0);

    // reset in the middle of an E0 F0 sequence
    scan_in = 8'hFD;
    send(8'h1C, 1, 8'hFB, 7'd1, 1'b0);
    send(8'h09, 1, 8'hFB, 7'd1, 1'b1);
    pfx(8'hE0);
    pfx(8'hF0);
    scan_in = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_code_ready", bus.code_ready, 1'b1);
    chk("midrst_scan_out", scan_out, 8'hFF);
    chk("midrst_keys_down", keys_down, 0);
    chk("midrst_restore", restore, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    scan_in = 8'hBF;
    send(8'h6C, 1, 8'hFF, 7'd0, 1'b0);
    pfx(8'hE0);
    send(8'h6C, 1, 8'hF7, 7'd1, 1'b0);

    // error byte from a prefix state
    pfx(8'hE0);
    send(8'h00, 2, 8'hFF, 7'd0, 1'b0);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
